// File: rtl/keycode_pio_pkg.sv
// ============================================================================
// Module      : keycode_pio_pkg
// Description : Register map and EVENT word layout for the keycode input PIO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keycode_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_EVENT   = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EV_EMPTY_BIT = 31;
    localparam int EV_OVF_BIT   = 30;
    localparam int EV_COUNT_LSB = 16;

endpackage

`default_nettype wire

// File: rtl/keycode_event_fifo.sv
// ============================================================================
// Module      : keycode_event_fifo
// Description : Small key-press event FIFO with sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keycode_event_fifo #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ovf_clr,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic w_do_pop;
    logic w_do_push;
    logic w_drop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_count    = r_count;
    assign o_overflow = r_ovf;
    assign o_head     = o_empty ? '0 : r_mem[r_rd_ptr];

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign w_drop    = i_push && o_full && !w_do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/keycode_in_pio.sv
// ============================================================================
// Module      : keycode_in_pio
// Description : Avalon-MM keycode input PIO: synchronizer, edge capture,
//               masked level irq and key-press event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keycode_in_pio
    import keycode_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] r_sync_chain [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic             r_irq;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_edge_clr;
    logic             w_rd;
    logic             w_wr;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;
    logic             w_empty;
    logic             w_full;
    logic [CNT_W-1:0] w_count;
    logic [31:0]      w_count32;
    logic             w_ovf;
    logic             w_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync_chain[i] <= '0;
            end
        end else begin
            r_sync_chain[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync_chain[i] <= r_sync_chain[i-1];
            end
        end
    end

    assign w_sync     = r_sync_chain[SYNC_STAGES-1];
    assign w_edge     = w_sync ^ r_prev;
    assign w_rd       = chipselect & ~read_n;
    assign w_wr       = chipselect & ~write_n;
    assign w_push     = (|w_edge) && (|w_sync);
    assign w_pop      = w_rd && (address == ADDR_EVENT);
    assign w_edge_clr = (w_wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= '0;
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_prev <= w_sync;
            if (w_wr && (address == ADDR_IRQMASK)) begin
                r_irq_mask <= writedata[WIDTH-1:0];
            end
            // New edges are OR-ed in after the clear so a colliding set wins.
            r_edge_cap <= (r_edge_cap & ~w_edge_clr) | w_edge;
            r_irq      <= |(r_edge_cap & r_irq_mask);
        end
    end

    assign irq = r_irq;

    keycode_event_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_data     (w_sync),
        .i_ovf_clr  (w_wr && (address == ADDR_EVENT)),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_count    (w_count),
        .o_overflow (w_ovf)
    );

    assign w_count32 = 32'(w_count);

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = w_sync;
            ADDR_EVENT: begin
                readdata[EV_EMPTY_BIT]          = w_empty;
                readdata[EV_OVF_BIT]            = w_ovf;
                readdata[EV_COUNT_LSB +: 3]     = w_count32[2:0];
                readdata[WIDTH-1:0]             = w_head;
            end
            ADDR_IRQMASK: readdata[WIDTH-1:0] = r_irq_mask;
            default:      readdata[WIDTH-1:0] = r_edge_cap;
        endcase
    end

    assign w_unused = ^{writedata, w_full, w_count32};

endmodule

`default_nettype wire

// File: tb/tb_keycode_in_pio.sv
// ============================================================================
// Module      : tb_keycode_in_pio
// Description : Self-checking bench for keycode_in_pio with an event scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keycode_in_pio;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       address = 2'd0;
    logic             chipselect = 1'b0;
    logic             read_n = 1'b1;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = 32'd0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port = '0;
    logic             irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q[$];
    logic       model_ovf = 1'b0;
    logic [7:0] model_prev = 8'd0;

    keycode_in_pio #(
        .WIDTH       (WIDTH),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_event();
        logic [31:0] w;
        int n;
        w = 32'd0;
        n = model_q.size();
        if (n == 0) w[31] = 1'b1;
        else        w[7:0] = model_q[0];
        w[30]    = model_ovf;
        w[18:16] = 3'(n);
        return w;
    endfunction

    task automatic model_press(input logic [7:0] v);
        if (v != model_prev && v != 8'd0) begin
            if (model_q.size() < DEPTH) model_q.push_back(v);
            else                        model_ovf = 1'b1;
        end
        model_prev = v;
    endtask

    task automatic do_reset(input logic [7:0] v);
        @(posedge clk); #1;
        reset = 1'b1; in_port = v; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        model_q.delete(); model_ovf = 1'b0; model_prev = 8'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_press(v);
    endtask

    task automatic press(input logic [7:0] v);
        @(posedge clk); #1 in_port = v;
        model_press(v);
        repeat (5) @(posedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        address = a; chipselect = 1'b1; read_n = 1'b0;
        #1 d = readdata;
        @(posedge clk); #1;
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    // Scoreboard: expected word comes from the model queue, then the entry retires.
    task automatic sb_read_event(output logic [31:0] got, output logic [31:0] exp);
        exp = exp_event();
        bus_read(2'd1, got);
        if (model_q.size() > 0) void'(model_q.pop_front());
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        do_reset(8'h00);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", irq); end
        bus_read(2'd0, got);
        checks++; if (got !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", got); end
        sb_read_event(got, exp);
        checks++; if (got !== 32'h8000_0000) begin errors++; $display("FAIL reset_event: got %h expected 80000000", got); end
        bus_read(2'd2, got);
        checks++; if (got !== 32'd0) begin errors++; $display("FAIL reset_irqmask: got %h expected 0", got); end
        bus_read(2'd3, got);
        checks++; if (got !== 32'd0) begin errors++; $display("FAIL reset_edgecap: got %h expected 0", got); end
    endtask

    task automatic test_edge_irq();
        logic [31:0] got, exp;
        do_reset(8'h00);
        bus_write(2'd2, 32'h04);
        @(posedge clk); #1 in_port = 8'h3C; address = 2'd0;
        model_press(8'h3C);
        @(posedge clk);
        @(posedge clk); #1;
        checks++; if (readdata !== 32'h3C) begin errors++; $display("FAIL data_latency: got %h expected 3c", readdata); end
        @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_not_early: got %0b expected 0", irq); end
        @(posedge clk); #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %0b expected 1", irq); end
        bus_read(2'd3, got);
        checks++; if (got !== 32'h3C) begin errors++; $display("FAIL edgecap_3c: got %h expected 3c", got); end
        bus_write(2'd3, 32'h04);
        @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %0b expected 0", irq); end
        bus_read(2'd3, got);
        checks++; if (got !== 32'h38) begin errors++; $display("FAIL edgecap_rw1c: got %h expected 38", got); end
        sb_read_event(got, exp);
        checks++; if (got !== exp) begin errors++; $display("FAIL event_3c: got %h expected %h", got, exp); end
    endtask

    task automatic test_fifo_order();
        logic [31:0] got, exp;
        do_reset(8'h00);
        press(8'h11); press(8'h00); press(8'h22); press(8'h33);
        for (int i = 0; i < 4; i++) begin
            sb_read_event(got, exp);
            checks++; if (got !== exp) begin errors++; $display("FAIL fifo_order[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] got, exp;
        do_reset(8'h00);
        for (int v = 1; v <= 6; v++) press(8'(v));
        sb_read_event(got, exp);
        checks++; if (got !== exp) begin errors++; $display("FAIL ovf_first: got %h expected %h", got, exp); end
        bus_write(2'd1, 32'hFFFF_FFFF);
        model_ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb_read_event(got, exp);
            checks++; if (got !== exp) begin errors++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] got, exp;
        do_reset(8'h00);
        for (int v = 1; v <= 4; v++) press(8'(v));
        @(posedge clk); #1 in_port = 8'h05;
        @(posedge clk);
        @(posedge clk); #1;
        address = 2'd1; chipselect = 1'b1; read_n = 1'b0;
        exp = exp_event();
        #1 got = readdata;
        checks++; if (got !== exp) begin errors++; $display("FAIL full_pushpop_head: got %h expected %h", got, exp); end
        @(posedge clk); #1;
        chipselect = 1'b0; read_n = 1'b1;
        void'(model_q.pop_front());
        model_press(8'h05);
        for (int i = 0; i < 5; i++) begin
            sb_read_event(got, exp);
            checks++; if (got !== exp) begin errors++; $display("FAIL full_pushpop_drain[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_rw1c_collision();
        logic [31:0] got;
        do_reset(8'h00);
        press(8'h01);
        @(posedge clk); #1 in_port = 8'h00;
        model_press(8'h00);
        @(posedge clk);
        @(posedge clk); #1;
        address = 2'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        bus_read(2'd3, got);
        checks++; if (got !== 32'h1) begin errors++; $display("FAIL rw1c_set_wins: got %h expected 1", got); end
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, got);
        checks++; if (got !== 32'h0) begin errors++; $display("FAIL rw1c_clear: got %h expected 0", got); end
    endtask

    task automatic test_reset_with_input();
        logic [31:0] got, exp;
        do_reset(8'h55);
        repeat (3) @(posedge clk);
        #1 address = 2'd0;
        #1;
        checks++; if (readdata !== 32'h55) begin errors++; $display("FAIL rel_data: got %h expected 55", readdata); end
        bus_read(2'd3, got);
        checks++; if (got !== 32'h55) begin errors++; $display("FAIL rel_edgecap: got %h expected 55", got); end
        sb_read_event(got, exp);
        checks++; if (got !== 32'h0001_0055 || got !== exp) begin errors++; $display("FAIL rel_event: got %h expected %h", got, exp); end
        bus_write(2'd2, 32'h55);
        @(posedge clk); #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_before_reset: got %0b expected 1", irq); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_reset: got %0b expected 0", irq); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge_irq();
        test_fifo_order();
        test_overflow();
        test_full_push_pop();
        test_rw1c_collision();
        test_reset_with_input();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
